aes_block_serializer: RTL and testbench

Read-side consumer of the one-entry 128-bit synchronous block register that holds AES results. When the register is full, the serializer pops the block in one cycle, then emits it as four 32-bit words on a valid/ready stream toward the 32-bit host/bus interface. If another block is waiting, it chains the next block back-to-back, so a downstream sink with `out_ready` held high sees no bubbles.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_block_serializer.sv | 69 ++++++
 tb/tb_aes_block_serializer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the block-serializer state encoding.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_WORD_BITS  = 32;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/aes_block_serializer.sv
// Pops 128-bit AES result blocks from a one-entry register and streams them MSW-first
// as OBITS-wide words on valid/ready. Optional out_last port under AES_SER_LAST_EN.
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter int WBITS = AES_BLOCK_BITS,
  parameter int OBITS = AES_WORD_BITS
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             src_empty,
  input  logic [WBITS-1:0] src_rdata,
  output logic             src_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OBITS-1:0] out_data,
  output logic             busy
`ifdef AES_SER_LAST_EN
  ,
  output logic             out_last
`endif
);

  localparam int NWORDS = WBITS / OBITS;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  ser_state_t       state_q;
  logic [WBITS-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;

  logic hs;
  logic last_word;

  assign out_valid = (state_q == SER_SEND);
  assign busy      = (state_q == SER_SEND);
  assign out_data  = shreg_q[WBITS-1 -: OBITS];
  assign hs        = out_valid & out_ready;
  assign last_word = (cnt_q == LAST_CNT);

  // A pop while sending is only allowed on the edge that retires the final word,
  // which is what lets chained blocks stream without a bubble.
  assign src_ren = resetn & ~src_empty &
                   ((state_q == SER_IDLE) | ((state_q == SER_SEND) & hs & last_word));

`ifdef AES_SER_LAST_EN
  assign out_last = out_valid & last_word;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (src_ren) begin
      state_q <= SER_SEND;
      shreg_q <= src_rdata;
      cnt_q   <= '0;
    end else if (hs) begin
      if (last_word) begin
        state_q <= SER_IDLE;
      end else begin
        shreg_q <= shreg_q << OBITS;
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed cycle-by-cycle bench for aes_block_serializer; define AES_SER_LAST_EN to check out_last.
module tb_aes_block_serializer;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  logic         clock;
  logic         resetn;
  logic         src_empty;
  logic [127:0] src_rdata;
  logic         src_ren;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;
`ifdef AES_SER_LAST_EN
  logic         out_last;
`endif

  aes_block_serializer dut (
    .clock     (clock),
    .resetn    (resetn),
    .src_empty (src_empty),
    .src_rdata (src_rdata),
    .src_ren   (src_ren),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES_SER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rstn;
    logic         empty;
    logic [127:0] rdata;
    logic         rdy;
    logic         e_ren;
    logic         e_vld;
    logic [31:0]  e_data;
    logic         e_busy;
    logic         e_last;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rstn, logic empty, logic [127:0] rdata, logic rdy,
                              logic e_ren, logic e_vld, logic [31:0] e_data,
                              logic e_busy, logic e_last);
    vec_t v;
    v.rstn = rstn; v.empty = empty; v.rdata = rdata; v.rdy = rdy;
    v.e_ren = e_ren; v.e_vld = e_vld; v.e_data = e_data;
    v.e_busy = e_busy; v.e_last = e_last;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Single block, no stalls
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 0, 32'h00000000, 0, 0));
    vecs.push_back(mk(1, 0, BLK_A, 1, 1, 0, 32'h00000000, 0, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h00112233, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h8899AABB, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'hCCDDEEFF, 1, 1));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 0, 32'hCCDDEEFF, 0, 0));
    // Back-to-back blocks: B offered during the last word of A
    vecs.push_back(mk(1, 0, BLK_A, 1, 1, 0, 32'hCCDDEEFF, 0, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h00112233, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h8899AABB, 1, 0));
    vecs.push_back(mk(1, 0, BLK_B, 1, 1, 1, 32'hCCDDEEFF, 1, 1));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'hFFEEDDCC, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'hBBAA9988, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'h77665544, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'h33221100, 1, 1));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 0, 32'h33221100, 0, 0));
    // Backpressure on word 1 (with a full source: no double pop), then on the last word
    vecs.push_back(mk(1, 0, BLK_A, 1, 1, 0, 32'h33221100, 0, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h00112233, 1, 0));
    vecs.push_back(mk(1, 0, BLK_B, 0, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 0, BLK_B, 0, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 0, BLK_B, 0, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h8899AABB, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 0, 0, 1, 32'hCCDDEEFF, 1, 1));
    vecs.push_back(mk(1, 1, BLK_A, 0, 0, 1, 32'hCCDDEEFF, 1, 1));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'hCCDDEEFF, 1, 1));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 0, 32'hCCDDEEFF, 0, 0));
    // Reset mid-block after word 1 is accepted
    vecs.push_back(mk(1, 0, BLK_A, 1, 1, 0, 32'hCCDDEEFF, 0, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h00112233, 1, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 1, 32'h44556677, 1, 0));
    vecs.push_back(mk(0, 0, BLK_B, 1, 0, 1, 32'h8899AABB, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 0, 32'h00000000, 0, 0));
    vecs.push_back(mk(1, 0, BLK_B, 1, 1, 0, 32'h00000000, 0, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'hFFEEDDCC, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'hBBAA9988, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'h77665544, 1, 0));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 1, 32'h33221100, 1, 1));
    vecs.push_back(mk(1, 1, BLK_B, 1, 0, 0, 32'h33221100, 0, 0));
    // Reset while idle with a full source must not pop
    vecs.push_back(mk(0, 0, BLK_A, 1, 0, 0, 32'h33221100, 0, 0));
    vecs.push_back(mk(1, 1, BLK_A, 1, 0, 0, 32'h00000000, 0, 0));

    resetn    = 1'b0;
    src_empty = 1'b1;
    src_rdata = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      @(negedge clock);
      resetn    = vecs[i].rstn;
      src_empty = vecs[i].empty;
      src_rdata = vecs[i].rdata;
      out_ready = vecs[i].rdy;
      #1;
      chk("src_ren",   i, {31'd0, src_ren},   {31'd0, vecs[i].e_ren});
      chk("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
      chk("out_data",  i, out_data,           vecs[i].e_data);
      chk("busy",      i, {31'd0, busy},      {31'd0, vecs[i].e_busy});
`ifdef AES_SER_LAST_EN
      chk("out_last",  i, {31'd0, out_last},  {31'd0, vecs[i].e_last});
`endif
    end

    // Empty source held for 20 cycles: nothing may move
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      resetn    = 1'b1;
      src_empty = 1'b1;
      src_rdata = BLK_B;
      out_ready = (c % 2) == 0;
      #1;
      chk("idle_src_ren",   1000 + c, {31'd0, src_ren},   32'd0);
      chk("idle_out_valid", 1000 + c, {31'd0, out_valid}, 32'd0);
      chk("idle_busy",      1000 + c, {31'd0, busy},      32'd0);
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
